// File: rtl/mod_req_arbiter_pkg.sv
// Shared definitions for the round-robin request arbiter.
// State encoding and a constant-width helper.
package mod_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/mod_rr_pick.sv
// Rotate-priority encoder: first set request at or above rr_ptr,
// wrapping around to bit 0.
module mod_rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic             found,
  output logic [PTR_W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[(int'(rr_ptr) + i) % N_REQ]) begin
        found = 1'b1;
        idx   = PTR_W'((int'(rr_ptr) + i) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/mod_req_arbiter.sv
// Shares one valid/ready target between N_REQ requesters,
// round-robin, one transaction in flight, with ack timeout.
module mod_req_arbiter
  import mod_req_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    req_err,
  output logic                    ext_req_valid,
  output logic [DATA_W-1:0]       ext_req_data,
  input  logic                    ext_req_ready,
  output logic                    busy
);

  localparam int PTR_W = clog2(N_REQ);
  localparam int CNT_W = clog2(TIMEOUT + 1);
  localparam logic [PTR_W-1:0] LAST =
    PTR_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT - 1);

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0]   grant, grant_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [N_REQ-1:0]   ready_nxt;
  logic               err_nxt;
  logic               ev_nxt;
  logic [DATA_W-1:0]  ed_nxt;
  logic               pick_found;
  logic [PTR_W-1:0]   pick_idx;

  mod_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant;
    cnt_nxt    = cnt;
    ready_nxt  = '0;
    err_nxt    = 1'b0;
    ev_nxt     = ext_req_valid;
    ed_nxt     = ext_req_data;
    unique case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (pick_found) begin
          grant_nxt = pick_idx;
          ed_nxt    = req_data[int'(pick_idx)*DATA_W +: DATA_W];
          ev_nxt    = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // ready beats timeout when both land on the same cycle
        if (ext_req_ready || cnt >= CNT_LAST) begin
          ev_nxt           = 1'b0;
          ready_nxt[grant] = 1'b1;
          err_nxt          = !ext_req_ready;
          state_nxt        = ST_RELEASE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        // wait for the target to drop ready so it is not reused
        if (!ext_req_ready) begin
          rr_ptr_nxt = (grant == LAST) ? '0 : grant + 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: begin
        ev_nxt    = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      grant         <= '0;
      cnt           <= '0;
      req_ready     <= '0;
      req_err       <= 1'b0;
      ext_req_valid <= 1'b0;
      ext_req_data  <= '0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      rr_ptr        <= rr_ptr_nxt;
      grant         <= grant_nxt;
      cnt           <= cnt_nxt;
      req_ready     <= ready_nxt;
      req_err       <= err_nxt;
      ext_req_valid <= ev_nxt;
      ext_req_data  <= ed_nxt;
      busy          <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_mod_req_arbiter.sv
// Scoreboard bench for mod_req_arbiter with a behavioural
// target that echoes valid, can stall, and can hold ready.
module tb_mod_req_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            req_err;
  logic            ext_req_valid;
  logic [DW-1:0]   ext_req_data;
  logic            ext_req_ready;
  logic            busy;

  mod_req_arbiter #(
    .N_REQ   (N),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .req_err       (req_err),
    .ext_req_valid (ext_req_valid),
    .ext_req_data  (ext_req_data),
    .ext_req_ready (ext_req_ready),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] data;
    bit          err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   lat   = 0;
  bit   prev_v = 1'b0;

  bit   ack_en    = 1'b1;
  int   ack_delay = 1;
  int   hold_cfg  = 0;
  int   hold_left = 0;
  int   vcnt      = 0;

  // target: registered ack after ack_delay valid cycles,
  // ready optionally held hold_cfg cycles past the drop
  initial ext_req_ready = 1'b0;
  always @(posedge clk) begin
    if (ext_req_valid) begin
      vcnt      <= vcnt + 1;
      hold_left <= hold_cfg;
      if (ack_en && vcnt + 1 >= ack_delay)
        ext_req_ready <= 1'b1;
    end else begin
      vcnt <= 0;
      if (hold_left != 0) hold_left <= hold_left - 1;
      else ext_req_ready <= 1'b0;
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               name, act, exp);
    end
  endtask

  task automatic push(input int idx, input logic [31:0] d,
                      input bit err, input int l);
    exp_t x;
    x.idx = idx; x.data = d; x.err = err; x.lat = l;
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ext_req_valid && !prev_v) begin
        lat = 0;
        chk("ready_low_at_issue", 32'(ext_req_ready), 0);
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_issue: data 0x%0h",
                   ext_req_data);
        end else begin
          chk("ext_data", ext_req_data, exp_q[0].data);
        end
      end else begin
        lat++;
      end
      if (req_ready != '0) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_pulse: got %b want none",
                   req_ready);
        end else begin
          e = exp_q.pop_front();
          chk("grant", 32'(req_ready), 32'(1) << e.idx);
          chk("err", 32'(req_err), 32'(e.err));
          chk("latency", lat, e.lat);
        end
      end
    end
    prev_v = ext_req_valid;
  end

  task automatic wait_idle(input int budget);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      req_valid &= ~req_ready;
      n++;
      if (req_valid == '0 && !busy) begin
        done = 1'b1;
      end else if (n >= budget) begin
        tests++; fails++;
        $display("FAIL wait_idle: got busy after %0d want idle", n);
        req_valid = '0;
        done = 1'b1;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_req_err"}, 32'(req_err), 0);
    chk({tag, "_ext_valid"}, 32'(ext_req_valid), 0);
    chk({tag, "_ext_data"}, ext_req_data, 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    req_valid = '0;
    req_data = {32'hC0DE_0003, 32'hC0DE_0002,
                32'hC0DE_0001, 32'hC0DE_0000};
    @(negedge clk);
    do_reset();

    // single request, 1-cycle issue latency
    req_data[95:64] = 32'h0000_00A5;
    push(2, 32'h0000_00A5, 1'b0, 2);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("issue_latency", 32'(ext_req_valid), 1);
    wait_idle(50);
    req_data[95:64] = 32'hC0DE_0002;

    // full round robin from rr_ptr=0, then wrap to 0
    do_reset();
    push(0, 32'hC0DE_0000, 1'b0, 2);
    push(1, 32'hC0DE_0001, 1'b0, 2);
    push(2, 32'hC0DE_0002, 1'b0, 2);
    push(3, 32'hC0DE_0003, 1'b0, 2);
    req_valid = 4'b1111;
    wait_idle(100);
    push(0, 32'hC0DE_0000, 1'b0, 2);
    push(1, 32'hC0DE_0001, 1'b0, 2);
    req_valid = 4'b0011;
    wait_idle(60);

    // silent target times out, next requester served
    ack_en = 1'b0;
    push(0, 32'hC0DE_0000, 1'b1, TO);
    req_valid = 4'b0001;
    wait_idle(60);
    ack_en = 1'b1;
    push(1, 32'hC0DE_0001, 1'b0, 2);
    req_valid = 4'b0010;
    wait_idle(60);

    // ack on the timeout cycle wins; one cycle later loses
    ack_delay = TO - 1;
    push(2, 32'hC0DE_0002, 1'b0, TO);
    req_valid = 4'b0100;
    wait_idle(60);
    ack_delay = TO;
    push(3, 32'hC0DE_0003, 1'b1, TO);
    req_valid = 4'b1000;
    wait_idle(60);
    ack_delay = 1;

    // target holds ready 5 cycles past the drop
    hold_cfg = 5;
    push(0, 32'hC0DE_0000, 1'b0, 2);
    push(1, 32'hC0DE_0001, 1'b0, 2);
    req_valid = 4'b0011;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == '0 && n < 50);
    chk("hold_first_pulse", 32'(req_ready), 32'b0001);
    req_valid &= ~req_ready;
    repeat (6) begin
      @(negedge clk);
      chk("hold_busy", 32'(busy), 1);
      chk("hold_no_reissue", 32'(ext_req_valid), 0);
    end
    wait_idle(60);
    hold_cfg = 0;

    // reset during ISSUE aborts silently and clears rr_ptr
    push(2, 32'hC0DE_0002, 1'b0, 2);
    req_valid = 4'b0100;
    wait_idle(60);
    ack_en = 1'b0;
    push(3, 32'hC0DE_0003, 1'b1, TO);
    req_valid = 4'b1000;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ext_req_valid && n < 20);
    chk("pre_reset_issue", 32'(ext_req_valid), 1);
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b0;
    req_valid = '0;
    @(negedge clk);
    check_zero("mid_reset");
    rst_n = 1'b1;
    ack_en = 1'b1;
    push(0, 32'hC0DE_0000, 1'b0, 2);
    push(3, 32'hC0DE_0003, 1'b0, 2);
    req_valid = 4'b1001;
    wait_idle(60);

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
